// File: rtl/clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared types and constants for the CPU clock-enable / single-step
// controller (clk_step_ctrl) and its key debouncer (key_debounce).
//   state_t        : controller FSM encoding (IDLE / RUN / HALT)
//   DEB_CYCLES_DEF : default key-stability window, 1 ms at 12.5 MHz
// ---------------------------------------------------------------------------
package clk_ctrl_pkg;

  // The ST_ prefix keeps the RUN state literal from colliding with the
  // RUN switch port on the top level.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam int DEB_CYCLES_DEF = 12500;

  // Modulo-2^N increment used by the pulse counter; the carry out is
  // intentionally discarded so the count wraps.
  function automatic logic [31:0] wrap_inc(input logic [31:0] val);
    wrap_inc = val + 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low step key, requires DEB_CYCLES consecutive
// cycles of disagreement with the accepted level before adopting the new
// level, and emits a one-cycle PRESS on each accepted press (1 -> 0).
// Releases produce no pulse.
// Ports:
//   CLK   in  system clock
//   CLRn  in  asynchronous active-low reset
//   KEYn  in  raw bouncing key, active low, asynchronous
//   PRESS out one-cycle registered press pulse
// ---------------------------------------------------------------------------
module key_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic CLRn,
  input  logic KEYn,
  output logic PRESS
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic          key_meta_q;
  logic          key_sync_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_q;
  logic          press_d;

  // Two-stage synchroniser for the key; idles at "released".
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= KEYn;
      key_sync_q <= key_meta_q;
    end
  end

  // Stability counter: any agreeing cycle restarts the window; the level
  // flips on the DEB_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    press_d = 1'b0;
    if (key_sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = key_sync_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
    // Only the falling (press) edge of the accepted level is reported.
    press_d = level_q & ~level_d;
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      level_q <= 1'b1;
      cnt_q   <= CNT_ZERO;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign PRESS = press_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// ---------------------------------------------------------------------------
// clk_step_ctrl
// Turns the slow divider square wave into single-cycle CPU execution
// enables. In free-run each T_SLOW rising edge yields one CPU_EN; when
// stopped, each debounced step-key press yields one CPU_EN; a CPU halt
// request parks the controller until the run switch is off and HLT clears.
// Ports:
//   CLK      in  system clock (only clock)
//   CLRn     in  asynchronous active-low reset
//   T_SLOW   in  slow square wave, asynchronous
//   RUN      in  run/stop switch (1 = free-run), asynchronous
//   STEP_Kn  in  raw single-step key, active low, bouncing
//   HLT      in  CPU halt request, synchronous to CLK
//   CPU_EN   out one-cycle execution enable (registered)
//   RUNNING  out FSM is in RUN (registered)
//   HALTED   out FSM is in HALT (registered)
//   STEP_CNT out number of CPU_EN pulses issued, wraps
// ---------------------------------------------------------------------------
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             CLRn,
  input  logic             T_SLOW,
  input  logic             RUN,
  input  logic             STEP_Kn,
  input  logic             HLT,
  output logic             CPU_EN,
  output logic             RUNNING,
  output logic             HALTED,
  output logic [CNT_W-1:0] STEP_CNT
);

  logic             t_meta_q;
  logic             t_sync_q;
  logic             t_prev_q;
  logic             run_meta_q;
  logic             run_sync_q;
  logic             tick_s;
  logic             step_req_s;

  state_t           state_q;
  state_t           state_d;
  logic             cpu_en_q;
  logic             cpu_en_d;
  logic             running_q;
  logic             running_d;
  logic             halted_q;
  logic             halted_d;
  logic [CNT_W-1:0] step_cnt_q;
  logic [CNT_W-1:0] step_cnt_d;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .CLK   (CLK),
    .CLRn  (CLRn),
    .KEYn  (STEP_Kn),
    .PRESS (step_req_s)
  );

  // Synchronisers for T_SLOW and RUN, plus the delayed T_SLOW for edge detect.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      t_meta_q   <= 1'b0;
      t_sync_q   <= 1'b0;
      t_prev_q   <= 1'b0;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      t_meta_q   <= T_SLOW;
      t_sync_q   <= t_meta_q;
      t_prev_q   <= t_sync_q;
      run_meta_q <= RUN;
      run_sync_q <= run_meta_q;
    end
  end

  // Rising edges of the slow clock only.
  assign tick_s = t_sync_q & ~t_prev_q;

  // Next-state and enable logic. The ~cpu_en_q guards keep the enable from
  // ever being high on two consecutive cycles.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_sync_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
        if (step_req_s && !cpu_en_q) begin
          cpu_en_d = 1'b1;
        end else begin
          cpu_en_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Halt beats stop beats tick; a tick coinciding with either is lost.
        if (HLT) begin
          state_d = ST_HALT;
        end else if (!run_sync_q) begin
          state_d = ST_IDLE;
        end else if (tick_s && !cpu_en_q) begin
          cpu_en_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!run_sync_q && !HLT) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
    if (cpu_en_d) begin
      step_cnt_d = CNT_W'(wrap_inc(32'(step_cnt_q)));
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state_q    <= ST_IDLE;
      cpu_en_q   <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      step_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign CPU_EN   = cpu_en_q;
  assign RUNNING  = running_q;
  assign HALTED   = halted_q;
  assign STEP_CNT = step_cnt_q;

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

CPU clock-enable controller that consumes the slow square wave from the board clock divider and turns it into single-cycle execution enables for the 8-bit CPU core. It also accepts a debounced single-step push button, a run/stop switch and the CPU's halt request. It sits between the divider and the CPU datapath. The CPU is clocked by CLK throughout and advances only when CPU_EN is high.

## Interface
- DEB_CYCLES, default 12500: number of consecutive stable CLK cycles required before the step-key level is accepted (1 ms at 12.5 MHz).
- CNT_W, default 8: width of STEP_CNT.

Ports:
- CLK — in, 1: system clock; the only clock in the block.
- CLRn — in, 1: reset, asynchronous, active-low; clock CLK.
- T_SLOW — in, 1: slow square wave from the divider; treated as asynchronous.
- RUN — in, 1: run/stop slide switch; 1 = free-run; asynchronous.
- STEP_Kn — in, 1: raw single-step push button; active-low and bouncing.
- HLT — in, 1: halt request from the CPU, synchronous to CLK.
- CPU_EN — out, 1: one-CLK-cycle execution enable.
- RUNNING — out, 1: high while the FSM is in RUN.
- HALTED — out, 1: high while the FSM is in HALT.
- STEP_CNT — out, CNT_W: count of CPU_EN pulses issued; wraps modulo 2^CNT_W.

## Operation
- **Synchronisers.** T_SLOW, RUN and STEP_Kn each pass through a 2-FF synchroniser.
  - Reset values: T_SLOW 0, RUN 0, STEP_Kn 1.
- **Tick.** tick = synced T_SLOW high AND its previous registered value low.
  - Only rising edges of T_SLOW produce a tick; falling edges are ignored.
- **Debounce.**
  - The debounced key level resets to 1 (released).
  - A counter of width $clog2(DEB_CYCLES+1) counts consecutive cycles in which the synced key differs from the debounced level.
  - The counter clears to 0 on any cycle in which they match.
  - On reaching DEB_CYCLES, the debounced level takes the synced value and the counter clears.
  - A 1→0 transition of the debounced level produces step_req for one cycle. Release produces nothing.
- **FSM.** States are IDLE, RUN and HALT; reset state is IDLE.
  - IDLE:
    - synced RUN=1 → RUN.
    - step_req → CPU_EN pulse; stay in IDLE.
    - Ticks are ignored.
  - RUN, priority order:
    - HLT=1 → HALT, no CPU_EN.
    - Else synced RUN=0 → IDLE, no CPU_EN.
    - Else tick → CPU_EN pulse.
    - step_req is ignored.
  - HALT:
    - No CPU_EN; step_req and tick are ignored.
    - Exits to IDLE only when synced RUN=0 and HLT=0 in the same cycle.
- **CPU_EN** is registered and is never high on two consecutive cycles.
- **STEP_CNT** increments in the same cycle that CPU_EN is registered high; 2^CNT_W−1 wraps to 0.
- **Reset mid-operation.**
  - Asserting CLRn low clears everything immediately.
  - A CPU_EN pulse in progress is truncated.
  - A partially counted debounce is lost.

## Timing
- Reset values:
  - CPU_EN = 0, RUNNING = 0, HALTED = 0, STEP_CNT = 0.
  - FSM = IDLE, debounce counter = 0.
- T_SLOW latency: a rising edge on T_SLOW (meeting setup) produces CPU_EN high immediately after the 3rd subsequent CLK rising edge, for exactly one cycle.
- RUN latency: a change on RUN updates RUNNING after the 3rd CLK rising edge.
- HLT latency: HLT sampled high in RUN sets HALTED on the next edge. A tick in that same cycle is dropped.
- Step latency: a clean press, held low, raises CPU_EN no earlier than DEB_CYCLES and no later than DEB_CYCLES+4 CLK edges after STEP_Kn falls.
- Bounce rejection: key glitches shorter than DEB_CYCLES cycles produce no CPU_EN.
- Combinational paths: none from any input to any output.

## Structure
- Package clk_ctrl_pkg contains:
  - state typedef: IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10.
  - default DEB_CYCLES constant.
- Sub-module key_debounce, instantiated once:
  - contains the synchroniser, stability counter and press-pulse logic.
  - parameter DEB_CYCLES.
  - ports: CLK, CLRn, KEYn, PRESS.
- Top level holds the remaining synchronisers, the tick detector, the FSM and STEP_CNT.

## Test plan
- **Reset and run.** Reset, RUN=0, T_SLOW toggling every 20 cycles → CPU_EN stays 0 and STEP_CNT=0. Set RUN=1 → RUNNING=1 after 3 edges, then one CPU_EN per T_SLOW rising edge (3 edges later); after 5 rising edges, STEP_CNT=5.
- **Debounce (DEB_CYCLES=4).**
  - In IDLE, STEP_Kn bounces 1-0-1-0 with 2-cycle pulses → no CPU_EN.
  - Then held low for 10 cycles → exactly one CPU_EN; STEP_CNT increments by 1.
  - Release → no pulse.
- **Halt.**
  - In RUN, HLT=1 in the same cycle as a tick → HALTED=1 next edge and no CPU_EN.
  - Steps and ticks while halted → none.
  - RUN=0 and HLT=0 → IDLE.
- **Run drop.** RUN falls while a tick coincides with the synced-RUN=0 cycle → FSM enters IDLE and no CPU_EN is issued.
- **Wrap.** CNT_W=8: issue 257 pulses → STEP_CNT=1.
- **Reset mid-operation.** CLRn pulsed low during the CPU_EN-high cycle and mid-debounce → all outputs 0 immediately. A subsequent press needs a full DEB_CYCLES window.
